// File: rtl/fir_pair_serializer.sv
// fir_pair_serializer: rounds and saturates L=2 FIR sum pairs,
// buffers them and replays them one sample per clock, even first.
module fir_pair_serializer #(
    parameter int IN_W  = 48,
    parameter int OUT_W = 24,
    parameter int SHIFT = 23,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  sum_even,
    input  logic [IN_W-1:0]  sum_odd,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_phase,
    output logic             out_sat,
    output logic             sat_sticky,
    input  logic             sat_clr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic signed [IN_W:0] RND  = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_W:0] MAXV =
        {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MINV =
        {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    // Each stored word carries its saturation flag in the MSB.
    logic [OUT_W:0] even_mem [DEPTH];
    logic [OUT_W:0] odd_mem  [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          phase_q, phase_d;
    logic          sticky_q, sticky_d;

    logic           push, pop, retire;
    logic [OUT_W:0] even_s, odd_s, head;

    // Round half-up at bit SHIFT-1, then clamp to the OUT_W range.
    function automatic logic [OUT_W:0] scale(input logic [IN_W-1:0] x);
        logic signed [IN_W:0] t;
        logic signed [IN_W:0] y;
        logic [OUT_W:0]       r;
        t = $signed({x[IN_W-1], x}) + RND;
        y = t >>> SHIFT;
        if (y > MAXV)
            r = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        else if (y < MINV)
            r = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        else
            r = {1'b0, y[OUT_W-1:0]};
        return r;
    endfunction

    // Handshakes, pointer/count/phase updates and output mux.
    always_comb begin
        in_ready  = reset && (count_q < DEPTH_C);
        out_valid = (count_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        retire    = pop && phase_q;

        even_s = scale(sum_even);
        odd_s  = scale(sum_odd);

        wr_ptr_d = push   ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = retire ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !retire)
            count_d = count_q + CW'(1);
        else if (!push && retire)
            count_d = count_q - CW'(1);

        phase_d = pop ? ~phase_q : phase_q;

        sticky_d = sticky_q;
        if (push && (even_s[OUT_W] || odd_s[OUT_W]))
            sticky_d = 1'b1;
        else if (sat_clr)
            sticky_d = 1'b0;

        head      = phase_q ? odd_mem[rd_ptr_q] : even_mem[rd_ptr_q];
        out_data  = out_valid ? head[OUT_W-1:0] : '0;
        out_sat   = out_valid && head[OUT_W];
        out_phase = phase_q;
        sat_sticky = sticky_q;
    end

    // Control state; cleared asynchronously so buffered pairs are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            phase_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            phase_q  <= phase_d;
            sticky_q <= sticky_d;
        end
    end

    // Pair storage; contents are only meaningful under count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            even_mem[wr_ptr_q] <= even_s;
            odd_mem[wr_ptr_q]  <= odd_s;
        end
    end

endmodule

// File: tb/tb_fir_pair_serializer.sv
// tb_fir_pair_serializer: directed and random checks of the
// pair serializer against a sample-queue reference model.
module tb_fir_pair_serializer;

    localparam int IN_W  = 48;
    localparam int OUT_W = 24;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  sum_even = '0;
    logic [IN_W-1:0]  sum_odd = '0;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_phase;
    logic             out_sat;
    logic             sat_sticky;
    logic             sat_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [OUT_W-1:0] q_d [$];
    bit               q_s [$];
    bit               m_sticky = 1'b0;
    bit               accepted = 1'b0;

    fir_pair_serializer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(23), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sum_even(sum_even), .sum_odd(sum_odd),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_phase(out_phase),
        .out_sat(out_sat), .sat_sticky(sat_sticky),
        .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // floor((x + 2^22) / 2^23), then clamp to 24-bit signed
    task automatic ref_scale(input logic [IN_W-1:0] x,
                             output logic [OUT_W-1:0] d, output bit s);
        longint v, t, y;
        v = longint'($signed(x));
        t = v + 64'sd4194304;
        y = t / 64'sd8388608;
        if ((t < 0) && (t % 64'sd8388608 != 0)) y = y - 1;
        if (y > 64'sd8388607) begin
            d = 24'h7FFFFF; s = 1'b1;
        end else if (y < -64'sd8388608) begin
            d = 24'h800000; s = 1'b1;
        end else begin
            d = y[OUT_W-1:0]; s = 1'b0;
        end
    endtask

    task automatic cyc();
        int n, entries;
        bit do_push, do_pop, se, so;
        logic [OUT_W-1:0] de, dox;
        #2;
        n = q_d.size();
        entries = (n + 1) / 2;
        chk("out_valid", 64'(out_valid), 64'(n != 0));
        chk("in_ready", 64'(in_ready), 64'(entries < DEPTH));
        chk("out_phase", 64'(out_phase), 64'(n % 2));
        if (n > 0) begin
            chk("out_data", 64'(out_data), 64'(q_d[0]));
            chk("out_sat", 64'(out_sat), 64'(q_s[0]));
        end else begin
            chk("idle_data", 64'(out_data), 64'(0));
            chk("idle_sat", 64'(out_sat), 64'(0));
        end
        chk("sat_sticky", 64'(sat_sticky), 64'(m_sticky));
        do_push = in_valid && (entries < DEPTH);
        do_pop  = out_ready && (n > 0);
        se = 1'b0; so = 1'b0; de = '0; dox = '0;
        if (do_push) begin
            ref_scale(sum_even, de, se);
            ref_scale(sum_odd, dox, so);
        end
        @(posedge clk);
        if (do_pop) begin
            void'(q_d.pop_front());
            void'(q_s.pop_front());
        end
        if (do_push) begin
            q_d.push_back(de); q_s.push_back(se);
            q_d.push_back(dox); q_s.push_back(so);
        end
        if (do_push && (se || so)) m_sticky = 1'b1;
        else if (sat_clr) m_sticky = 1'b0;
        accepted = do_push;
        #1;
    endtask

    task automatic push_pair(input logic [IN_W-1:0] e,
                             input logic [IN_W-1:0] o);
        int k;
        in_valid = 1'b1; sum_even = e; sum_odd = o;
        k = 0;
        do begin
            cyc();
            k++;
        end while (!accepted && k < 50);
        if (!accepted) chk("push_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        out_ready = 1'b1;
        k = 0;
        while (q_d.size() != 0 && k < 50) begin
            cyc();
            k++;
        end
        chk("drain_empty", 64'(q_d.size()), 64'(0));
        cyc();
    endtask

    function automatic logic [IN_W-1:0] rnd_sum();
        logic [63:0] tmp;
        logic [IN_W-1:0] r;
        int sh;
        tmp = {$urandom(), $urandom()};
        r = tmp[IN_W-1:0];
        if ($urandom_range(0, 3) == 0) begin
            r = 48'($signed(r) >>> 23);
            r = (r << 23) + 48'h400000;
        end else begin
            sh = $urandom_range(0, 30);
            r = 48'($signed(r) >>> sh);
        end
        return r;
    endfunction

    initial begin
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_phase", 64'(out_phase), 64'(0));
        chk("rst_sticky", 64'(sat_sticky), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        out_ready = 1'b1;
        push_pair(48'h800000, 48'h1000000);
        chk("first_even", 64'(out_data), 64'(1));
        drain();

        push_pair(48'h400000, 48'h3FFFFF);
        drain();
        push_pair(-48'sh400000, -48'sh400001);
        drain();

        push_pair(48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000);
        chk("sat_even", 64'(out_data), 64'(24'h7FFFFF));
        drain();
        sat_clr = 1'b1;
        cyc();
        sat_clr = 1'b0;
        cyc();

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push_pair(48'(2*i+1) << 23, 48'(2*i+2) << 23);
        in_valid = 1'b1;
        sum_even = 48'(9) << 23;
        sum_odd  = 48'(10) << 23;
        repeat (3) cyc();
        chk("full_stall", 64'(accepted), 64'(0));
        out_ready = 1'b1;
        push_pair(48'(9) << 23, 48'(10) << 23);
        drain();

        begin
            int k;
            k = 20;
            out_ready = 1'b1;
            for (int i = 0; i < 24; i++) begin
                in_valid = 1'b1;
                sum_even = 48'(k) << 23;
                sum_odd  = 48'(k + 1) << 23;
                cyc();
                if (accepted) k += 2;
                out_ready = ~out_ready;
            end
            in_valid = 1'b0;
            drain();
        end

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            push_pair(48'(100 + i) << 23, 48'(200 + i) << 23);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        cyc();
        chk("pre_rst_phase", 64'(out_phase), 64'(1));
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_phase", 64'(out_phase), 64'(0));
        chk("mid_rst_ready", 64'(in_ready), 64'(0));
        q_d.delete();
        q_s.delete();
        m_sticky = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        push_pair(48'(11) << 23, 48'(12) << 23);
        chk("post_rst_even", 64'(out_data), 64'(11));
        drain();

        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            sat_clr   = ($urandom_range(0, 7) == 0);
            sum_even  = rnd_sum();
            sum_odd   = rnd_sum();
            cyc();
        end
        in_valid = 1'b0;
        sat_clr  = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_pair_serializer.md
Name: fir_pair_serializer

Overview:
- Downstream stage of the 2-parallel (L=2) FIR filter.
- Accepts one pair of full-precision 48-bit accumulator results (sum_even, sum_odd) per handshake.
- Rounds and saturates each result to 24-bit output samples, then buffers the pairs in a small FIFO.
- Emits one sample per clock in time order (even, then odd) over a valid/ready stream, giving a single-rate output to the DAC/serial sink.

Parameters:
- IN_W, 48, width of the signed accumulator inputs.
- OUT_W, 24, width of the signed output samples.
- SHIFT, 23, right-shift applied before rounding (Q1.23 coefficients); legal range 1..IN_W-OUT_W.
- DEPTH, 4, FIFO depth in pairs; power of 2, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state).
- in_valid  in  1  the sum_even/sum_odd pair is valid.
- in_ready  out  1  the block can accept a pair this cycle.
- sum_even  in  IN_W  signed even-phase filter sum (earlier sample in time).
- sum_odd  in  IN_W  signed odd-phase filter sum (later sample in time).
- out_data  out  OUT_W  signed scaled output sample.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts out_data this cycle.
- out_phase  out  1  0 = even sample, 1 = odd sample.
- out_sat  out  1  the current out_data was saturated.
- sat_sticky  out  1  set when any accepted sample saturates.
- sat_clr  in  1  synchronous clear of sat_sticky.

Behaviour:
- Reset (async, reset==0): FIFO count, read/write pointers, out_phase and sat_sticky all go to 0. out_valid=0 and in_ready=0 while reset is low. FIFO storage is not reset.
- out_data=0 and out_sat=0 whenever out_valid=0, including after reset.
- in_ready = (count < DEPTH), decoded from registered count only. Space freed by a pop in the same cycle is not used (no bypass).
- Push: on a rising edge with in_valid && in_ready, both scaled samples and their sat flags are written as one entry and count increments.
- in_valid && !in_ready is a stall: nothing is written, and upstream must hold the pair.
- Scaling, applied per sample at write time:
  - t = x + 2^(SHIFT-1), computed in IN_W+1 bits.
  - y = t >>> SHIFT (arithmetic shift).
  - If y > 2^(OUT_W-1)-1, output 0x7FFFFF with sat=1.
  - If y < -2^(OUT_W-1), output 0x800000 with sat=1.
  - Otherwise output y[OUT_W-1:0] with sat=0.
  - Rounding is round-half-up (toward +inf on ties).
- out_valid = (count != 0). out_data and out_sat are muxed combinationally from the head entry by out_phase.
- Pop: on a rising edge with out_valid && out_ready:
  - if out_phase==0, out_phase becomes 1;
  - if out_phase==1, out_phase becomes 0, the head entry retires and count decrements.
- Simultaneous push and retire: count is unchanged and pointers advance independently. Pointers wrap modulo DEPTH.
- Latency: a pair pushed into an empty FIFO at edge k gives out_valid=1 with the even sample after edge k. Its odd sample is presented after the next accepted pop.
- Throughput is at most 1 output sample/clock, so upstream sees in_ready deassert under sustained 1-pair/clock input.
- out_data and out_phase hold stable while out_valid && !out_ready.
- sat_sticky is set on any push whose even or odd sample saturates.
  - sat_clr clears it at the next edge.
  - A same-cycle set takes priority over clear.
- Reset mid-operation discards all buffered pairs and returns out_phase to 0. After reset releases, the first output is the even sample of the first new pair.

Test Plan:
- Reset, then push {sum_even=0x800000, sum_odd=0x1000000} with out_ready=1: outputs 1 (phase 0) then 2 (phase 1) on consecutive cycles; out_sat=0; FIFO then empty.
- Rounding: push {0x400000, 0x3FFFFF} -> outputs 1, 0. Push {-0x400000, -0x400001} -> outputs 0, -1.
- Saturation: push {2^47-1, -2^47} -> outputs 0x7FFFFF and 0x800000, each with out_sat=1; sat_sticky=1. Pulse sat_clr -> sat_sticky=0.
- Backpressure: out_ready=0, push pairs (1,2),(3,4),(5,6),(7,8) -> in_ready=0 after the 4th push. Hold (9,10) on the inputs, then raise out_ready -> outputs 1..10 in order, with no loss or duplication.
- Alternate out_ready 1/0 each cycle while pushing continuous pairs (k, k+1) -> output sequence strictly increasing, and out_data stable during each stall.
- Assert reset low with 3 pairs buffered and out_phase=1 -> out_valid=0 and out_phase=0 immediately. After release, push (11,12) -> outputs 11 then 12.
